// File: rtl/servo_pwm_if.sv
// Drive-control to servo-array bus: per-channel commands/enables in, pulses and status out.
interface servo_pwm_if #(
  parameter int unsigned NCH = 2
);
  logic [2*NCH-1:0] cmd;
  logic [NCH-1:0]   en;
  logic [NCH-1:0]   pwm;
  logic [NCH-1:0]   settled;
  logic             frame_start;

  modport master (output cmd, en, input pwm, settled, frame_start);
  modport slave  (input cmd, en, output pwm, settled, frame_start);
endinterface

// File: rtl/servo_pwm_array.sv
// Multi-channel servo PWM: one shared frame counter, widths committed only at frame
// boundaries with an optional per-frame slew limit.
module servo_pwm_array #(
  parameter int unsigned NCH    = 2,
  parameter int unsigned PERIOD = 3072,
  parameter int unsigned T_BACK = 154,
  parameter int unsigned T_STOP = 230,
  parameter int unsigned T_FWD  = 307,
  parameter int unsigned STEP   = 0
) (
  input  logic         clk,
  input  logic         reset,
  servo_pwm_if.slave   bus
);

  localparam int unsigned CW = $clog2(PERIOD + 1);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_commit;

  function automatic logic [CW-1:0] f_decode(input logic [1:0] c);
    case (c)
      2'b01:   return CW'(T_FWD);
      2'b10:   return CW'(T_BACK);
      default: return CW'(T_STOP);
    endcase
  endfunction

  always_comb begin
    w_commit  = (r_cnt == CW'(PERIOD - 1));
    w_cnt_nxt = w_commit ? '0 : r_cnt + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) r_cnt <= '0;
    else       r_cnt <= w_cnt_nxt;
  end

  // Combinational so the first cycle after reset release already flags cnt == 0.
  assign bus.frame_start = (r_cnt == '0) && !reset;

  for (genvar k = 0; k < int'(NCH); k++) begin : g_ch
    logic [CW-1:0] r_wid;
    logic [CW-1:0] r_tgt;
    logic          r_en;
    logic          r_pwm;
    logic [CW-1:0] w_dec;
    logic [CW-1:0] w_diff;
    logic [CW-1:0] w_slew;
    logic [CW-1:0] w_wid_nxt;
    logic          w_en_nxt;

    // Next width: jump when within one step (or unlimited), else move by exactly STEP.
    always_comb begin
      w_dec  = f_decode(bus.cmd[2*k +: 2]);
      w_diff = (w_dec > r_wid) ? (w_dec - r_wid) : (r_wid - w_dec);
      if (STEP == 0 || 32'(w_diff) <= STEP) w_slew = w_dec;
      else if (w_dec > r_wid)               w_slew = r_wid + CW'(STEP);
      else                                  w_slew = r_wid - CW'(STEP);
      w_wid_nxt = w_commit ? w_slew    : r_wid;
      w_en_nxt  = w_commit ? bus.en[k] : r_en;
    end

    // pwm is precomputed against the counter value of the following cycle.
    always_ff @(posedge clk) begin
      if (reset) begin
        r_wid <= CW'(T_STOP);
        r_tgt <= CW'(T_STOP);
        r_en  <= 1'b0;
        r_pwm <= 1'b0;
      end else begin
        r_wid <= w_wid_nxt;
        r_en  <= w_en_nxt;
        if (w_commit) r_tgt <= w_dec;
        r_pwm <= w_en_nxt && (w_cnt_nxt < w_wid_nxt);
      end
    end

    assign bus.pwm[k]     = r_pwm;
    assign bus.settled[k] = (r_wid == r_tgt);
  end

endmodule

// File: tb/tb_servo_pwm_array.sv
// Frame-level directed bench for servo_pwm_array: each table row is one frame of stimulus
// with the pulse widths and settled state expected in that frame.
module tb_servo_pwm_array;

  localparam int unsigned NCH    = 2;
  localparam int unsigned PERIOD = 200;

  typedef struct {
    int         chg_at;   // cnt at which cmd/en are driven (-1: never)
    logic [3:0] cmd;
    logic [1:0] en;
    int         rev_at;   // cnt at which cmd is reverted (-1: never)
    logic [3:0] cmd_rev;
    int         exp0;     // expected high cycles ch0 in this frame
    int         exp1;
    logic [1:0] exp_set;  // expected settled at cnt == 0 of this frame
  } vec_t;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] cmd   = 4'b0000;
  logic [1:0] en    = 2'b00;
  bit         dsel  = 1'b0;
  int         errors = 0;
  int         checks = 0;
  vec_t       tab0[$];
  vec_t       tab2[$];

  servo_pwm_if #(.NCH(NCH)) b0 ();
  servo_pwm_if #(.NCH(NCH)) b2 ();

  assign b0.cmd = cmd;
  assign b0.en  = en;
  assign b2.cmd = cmd;
  assign b2.en  = en;

  servo_pwm_array #(.NCH(NCH), .PERIOD(PERIOD), .T_BACK(10), .T_STOP(15), .T_FWD(20), .STEP(0))
    u_dut0 (.clk(clk), .reset(reset), .bus(b0.slave));
  servo_pwm_array #(.NCH(NCH), .PERIOD(PERIOD), .T_BACK(10), .T_STOP(15), .T_FWD(20), .STEP(2))
    u_dut2 (.clk(clk), .reset(reset), .bus(b2.slave));

  always #5 clk = ~clk;

  function automatic logic [1:0] get_pwm();
    return dsel ? b2.pwm : b0.pwm;
  endfunction
  function automatic logic [1:0] get_set();
    return dsel ? b2.settled : b0.settled;
  endfunction
  function automatic logic get_fs();
    return dsel ? b2.frame_start : b0.frame_start;
  endfunction

  function automatic vec_t mk(input int chg, input logic [3:0] c, input logic [1:0] e,
                              input int rev, input logic [3:0] cr,
                              input int e0, input int e1, input logic [1:0] s);
    vec_t v;
    v.chg_at = chg; v.cmd = c; v.en = e; v.rev_at = rev; v.cmd_rev = cr;
    v.exp0 = e0; v.exp1 = e1; v.exp_set = s;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one frame starting in the cnt == 0 cycle and checks widths, shape and flags.
  task automatic run_vec(input vec_t v, input string tag);
    int         hi0 = 0;
    int         hi1 = 0;
    int         fsbad = 0;
    logic [1:0] fell = 2'b00;
    logic [1:0] bad  = 2'b00;
    logic [1:0] set0 = 2'b00;
    logic [1:0] p;
    for (int i = 0; i < int'(PERIOD); i++) begin
      if (i == v.chg_at) begin
        cmd = v.cmd;
        en  = v.en;
      end
      if (i == v.rev_at) cmd = v.cmd_rev;
      #0;
      if (i == 0) set0 = get_set();
      p = get_pwm();
      for (int k = 0; k < 2; k++) begin
        if (p[k]) begin
          if (fell[k]) bad[k] = 1'b1;
        end else begin
          fell[k] = 1'b1;
        end
      end
      hi0 += int'(p[0]);
      hi1 += int'(p[1]);
      if (get_fs() !== (i == 0)) fsbad++;
      step();
    end
    chk({tag, " width0"}, hi0, v.exp0);
    chk({tag, " width1"}, hi1, v.exp1);
    chk({tag, " shape"}, int'(bad), 0);
    chk({tag, " settled"}, int'(set0), int'(v.exp_set));
    chk({tag, " frame_start"}, fsbad, 0);
  endtask

  initial begin
    // STEP = 0 device: startup, latency, capture window, stop codes, enable gating
    tab0.push_back(mk(0,   4'b1001, 2'b11, -1, 4'b0000,  0,  0, 2'b11));
    tab0.push_back(mk(0,   4'b1001, 2'b11, -1, 4'b0000, 20, 10, 2'b11));
    tab0.push_back(mk(0,   4'b1001, 2'b11, -1, 4'b0000, 20, 10, 2'b11));
    tab0.push_back(mk(5,   4'b1010, 2'b11, -1, 4'b0000, 20, 10, 2'b11));
    tab0.push_back(mk(0,   4'b1001, 2'b11, -1, 4'b0000, 10, 10, 2'b11));
    tab0.push_back(mk(199, 4'b1010, 2'b11, -1, 4'b0000, 20, 10, 2'b11));
    tab0.push_back(mk(0,   4'b1001, 2'b11, -1, 4'b0000, 10, 10, 2'b11));
    tab0.push_back(mk(198, 4'b1010, 2'b11, 199, 4'b1001, 20, 10, 2'b11));
    tab0.push_back(mk(0,   4'b1001, 2'b11, -1, 4'b0000, 20, 10, 2'b11));
    tab0.push_back(mk(0,   4'b1000, 2'b11, -1, 4'b0000, 20, 10, 2'b11));
    tab0.push_back(mk(0,   4'b1011, 2'b11, -1, 4'b0000, 15, 10, 2'b11));
    tab0.push_back(mk(0,   4'b1011, 2'b01, -1, 4'b0000, 15, 10, 2'b11));
    tab0.push_back(mk(0,   4'b1011, 2'b01, -1, 4'b0000, 15,  0, 2'b11));
    tab0.push_back(mk(0,   4'b1011, 2'b11, -1, 4'b0000, 15,  0, 2'b11));
    tab0.push_back(mk(0,   4'b1011, 2'b11, -1, 4'b0000, 15, 10, 2'b11));
    // STEP = 2 device: ramp 15 -> 20 then 20 -> 10, ch1 held at stop
    tab2.push_back(mk(0,   4'b1101, 2'b11, -1, 4'b0000,  0,  0, 2'b11));
    tab2.push_back(mk(0,   4'b1101, 2'b11, -1, 4'b0000, 17, 15, 2'b10));
    tab2.push_back(mk(0,   4'b1101, 2'b11, -1, 4'b0000, 19, 15, 2'b10));
    tab2.push_back(mk(0,   4'b1110, 2'b11, -1, 4'b0000, 20, 15, 2'b11));
    tab2.push_back(mk(0,   4'b1110, 2'b11, -1, 4'b0000, 18, 15, 2'b10));
    tab2.push_back(mk(0,   4'b1110, 2'b11, -1, 4'b0000, 16, 15, 2'b10));
    tab2.push_back(mk(0,   4'b1110, 2'b11, -1, 4'b0000, 14, 15, 2'b10));
    tab2.push_back(mk(0,   4'b1110, 2'b11, -1, 4'b0000, 12, 15, 2'b10));
    tab2.push_back(mk(0,   4'b1110, 2'b11, -1, 4'b0000, 10, 15, 2'b11));

    dsel = 1'b0;
    repeat (3) step();
    chk("reset frame_start", int'(b0.frame_start), 0);
    chk("reset pwm", int'(b0.pwm), 0);
    chk("reset settled", int'(b0.settled), 3);
    reset = 1'b0;
    #1;
    chk("release frame_start", int'(b0.frame_start), 1);

    foreach (tab0[r]) run_vec(tab0[r], $sformatf("s0 row%0d", r));

    // Mid-pulse reset: ch0 is 15 wide, so it is high at cnt = 8
    repeat (8) step();
    chk("prereset pwm0", int'(b0.pwm[0]), 1);
    reset = 1'b1;
    step();
    chk("midreset pwm", int'(b0.pwm), 0);
    chk("midreset frame_start", int'(b0.frame_start), 0);
    chk("midreset settled", int'(b0.settled), 3);
    reset = 1'b0;
    #1;
    chk("rerelease frame_start", int'(b0.frame_start), 1);
    run_vec(mk(0, 4'b1011, 2'b11, -1, 4'b0000,  0,  0, 2'b11), "post reset f0");
    run_vec(mk(0, 4'b1011, 2'b11, -1, 4'b0000, 15, 10, 2'b11), "post reset f1");

    dsel  = 1'b1;
    cmd   = 4'b0000;
    en    = 2'b00;
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    chk("s2 release frame_start", int'(b2.frame_start), 1);
    foreach (tab2[r]) run_vec(tab2[r], $sformatf("s2 row%0d", r));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/servo_pwm_array.md
# servo_pwm_array

Multi-channel servo PWM generator: NCH continuous-rotation servo outputs share one frame counter. Each channel turns a 2-bit drive command into a pulse width and applies it only at frame boundaries, so no pulse is ever truncated or stretched. An optional per-frame slew limit ramps widths toward their targets. It sits between the drive-control logic and the servo pins and generalises the single-channel motor driver.

## Interface
Parameters:
- NCH, 2: number of servo channels.
- PERIOD, 3072: frame length in clk cycles. The counter runs 0..PERIOD-1.
- T_BACK, 154: pulse width in cycles for command back.
- T_STOP, 230: pulse width in cycles for command stop.
- T_FWD, 307: pulse width in cycles for command forward.
- STEP, 0: maximum width change per frame in cycles. 0 means jump straight to target.
- Derived: CW = $clog2(PERIOD+1), the width of the counter and all width registers.
- Legal configuration: all T_* ≤ PERIOD-1, so every frame has at least one low cycle.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- cmd  in  2*NCH  per-channel command; channel k uses bits [2k+1:2k]. 01 = forward, 10 = back, 11 or 00 = stop.
- en  in  NCH  per-channel output enable.
- pwm  out  NCH  servo pulse outputs, driven directly from flops.
- settled  out  NCH  high when the channel's current width equals its committed target.
- frame_start  out  1  one-cycle pulse in each cycle where cnt == 0.

## Operation
- Frame counter cnt:
  - Increments every cycle.
  - Wraps from PERIOD-1 to 0.
- Commit cycle is the cycle where cnt == PERIOD-1. In it, each channel k does the following:
  - tgt_q[k] <= decode(cmd[k]).
  - en_q[k] <= en[k].
  - wid_q[k] is updated:
    - If STEP == 0, or |decode(cmd[k]) − wid_q[k]| ≤ STEP: wid_q[k] <= decode(cmd[k]).
    - Otherwise wid_q[k] moves toward decode(cmd[k]) by exactly STEP.
  - The slew comparison is unsigned. The decrement never underflows because the target is ≥ 0 and the step is bounded by the difference.
- Outside the commit cycle, cmd and en are ignored. tgt_q, en_q and wid_q hold.
- pwm[k] is 1 in a cycle iff en_q[k] == 1 and cnt < wid_q[k], using the cnt value of that same cycle.
  - The implementation registers the comparison against the next counter value.
  - wid_q == 0 gives a constant-low output.
- Width ramping continues while a channel is disabled. Re-enabling resumes at the current wid_q.
- settled[k] = (wid_q[k] == tgt_q[k]), registered or equivalent combinational from flops.
- frame_start = (cnt == 0) and not reset.
- Channels are fully independent apart from the shared cnt. Simultaneous commits on all channels are normal operation.

## Timing
- Reset values:
  - cnt = 0.
  - tgt_q = wid_q = T_STOP on all channels.
  - en_q = 0, so pwm = 0 and settled = all 1.
  - frame_start = 0 while reset is high.
- First cycle after reset release: cnt = 0 and frame_start = 1. pwm stays low for that entire frame because en_q = 0.
- Command latency:
  - A cmd/en value present during commit cycle N controls pwm from cycle N+1 (cnt = 0) onward.
  - A value present only before the commit cycle, and changed before it, is never seen.
- A mid-frame change on cmd or en has no effect on the current pulse.
- Ramp duration from width A to target B: ceil(|B−A|/STEP) frames. settled rises in the first cycle of the frame where wid_q == B.
- Reset asserted mid-frame, including during the high phase:
  - pwm goes to 0 in the next cycle.
  - All state returns to reset values. No partial pulse resumes.
- Output pulse shape: high for exactly wid_q consecutive cycles starting at cnt = 0, then low for PERIOD − wid_q cycles.

## Test plan
All scenarios use PERIOD=200, T_BACK=10, T_STOP=15, T_FWD=20, NCH=2.
1. STEP=0. Reset, then hold en=11, cmd ch0=01, ch1=10 → frame 0 both pwm low. Frame 1 onward: ch0 high for cnt 0..19 and low for 180 cycles; ch1 high for cnt 0..9. frame_start pulses every 200 cycles.
2. STEP=0. ch0 running forward; set cmd ch0=10 at cnt=5, hold → current frame still 20 high cycles, next frame 10. Repeat with cmd changed for only the single cycle at cnt=199 → captured, next frame 10. Change at cnt=198 and revert at cnt=199 → not captured.
3. STEP=2. From stop, set ch0=01 → successive frame widths 17, 19, 20. settled[0] low during the 17 and 19 frames, high from the 20 frame. Then cmd=10 → widths 18, 16, …, 10.
4. cmd 00 and 11 on ch0 → 15-cycle pulses. en[1]=0 latched at a commit → ch1 low from the next frame while ch0 is unaffected. Re-enable → pulse returns at the held width.
5. Reset asserted for one cycle at cnt=8 while ch0 is high → pwm 0 next cycle, cnt restarts at 0, widths 15, en_q=0, no output until a new commit with en=1.
